// File: rtl/frame_update_scheduler.sv
// Frame-synchronised game update scheduler: once every FRAME_DIV frames it
// asks the compute engine for one update and atomically commits the result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   hsyncReg, vsyncReg  VGA pixel/line counters (frame end detection)
//   pause               level, blocks new updates from starting
//   compute_done        engine pulse: positions on *In are ready
//   ballIn, leftPaddleIn, rightPaddleIn     engine results
//   ballOut, leftPaddleOut, rightPaddleOut  committed positions
//   compute_start       one-cycle update request
//   commit              one-cycle pulse, positions changed this cycle
//   busy                an update is in flight
//   skip_cnt            saturating count of frame ends seen while busy
//   timeout_err         sticky, engine did not answer in time
module frame_update_scheduler #(
    parameter int HSYNC_ACTIVE = 639,
    parameter int VSYNC_ACTIVE = 479,
    parameter int FRAME_DIV    = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hsyncReg,
    input  logic [9:0]  vsyncReg,
    input  logic        pause,
    input  logic        compute_done,
    input  logic [31:0] ballIn,
    input  logic [31:0] leftPaddleIn,
    input  logic [31:0] rightPaddleIn,
    output logic [31:0] ballOut,
    output logic [31:0] leftPaddleOut,
    output logic [31:0] rightPaddleOut,
    output logic        compute_start,
    output logic        commit,
    output logic        busy,
    output logic [7:0]  skip_cnt,
    output logic        timeout_err
);

    localparam int              TW       = $clog2(TIMEOUT);
    localparam logic [7:0]      DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        COMMIT
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          at_end;
    logic          at_end_q;
    logic          frame_end;
    logic [7:0]    div_cnt;
    logic [TW-1:0] to_cnt;

    logic          div_inc;
    logic          div_clr;
    logic          to_clr;
    logic          to_inc;
    logic          set_err;
    logic          load;
    logic          skip_inc;

    assign at_end = (hsyncReg == 10'(HSYNC_ACTIVE)) &&
                    (vsyncReg == 10'(VSYNC_ACTIVE));

    // The counters dwell on the last pixel for a while; only the first
    // cycle of that dwell counts as a frame end.
    assign frame_end = at_end && !at_end_q;

    assign skip_inc = frame_end && (state != IDLE) && (skip_cnt != 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_inc       = 1'b0;
        div_clr       = 1'b0;
        to_clr        = 1'b0;
        to_inc        = 1'b0;
        set_err       = 1'b0;
        load          = 1'b0;
        compute_start = 1'b0;
        commit        = 1'b0;
        busy          = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (frame_end) begin
                    if (div_cnt == DIV_LAST) begin
                        // A paused frame still consumes its divider slot.
                        div_clr = 1'b1;
                        if (!pause) begin
                            state_nxt = START;
                        end
                    end else begin
                        div_inc = 1'b1;
                    end
                end
            end
            START: begin
                compute_start = 1'b1;
                to_clr        = 1'b1;
                state_nxt     = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (compute_done) begin
                    // Capture with the done pulse so the new positions are
                    // visible during the COMMIT cycle itself.
                    load      = 1'b1;
                    state_nxt = COMMIT;
                end else if (to_cnt == TO_LAST) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            at_end_q       <= 1'b0;
            div_cnt        <= 8'd0;
            to_cnt         <= '0;
            skip_cnt       <= 8'd0;
            timeout_err    <= 1'b0;
            ballOut        <= 32'd0;
            leftPaddleOut  <= 32'd0;
            rightPaddleOut <= 32'd0;
        end else begin
            at_end_q <= at_end;
            if (div_clr) begin
                div_cnt <= 8'd0;
            end else if (div_inc) begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (to_clr) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (skip_inc) begin
                skip_cnt <= skip_cnt + 8'd1;
            end
            if (set_err) begin
                timeout_err <= 1'b1;
            end
            if (load) begin
                ballOut        <= ballIn;
                leftPaddleOut  <= leftPaddleIn;
                rightPaddleOut <= rightPaddleIn;
            end
        end
    end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench for frame_update_scheduler: two instances (divide by 1
// and by 3) share one stimulus stream and are checked against a model.
module tb_frame_update_scheduler;

    localparam int TO  = 16;
    localparam int FD0 = 1;
    localparam int FD1 = 3;
    localparam int PI  = 0;
    localparam int PS  = 1;
    localparam int PW  = 2;
    localparam int PC  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        h;
    logic [9:0]        v;
    logic              pause;
    logic              done;
    logic [31:0]       bin;
    logic [31:0]       lin;
    logic [31:0]       rin;
    logic [1:0][31:0]  bo;
    logic [1:0][31:0]  lo;
    logic [1:0][31:0]  ro;
    logic [1:0]        cs;
    logic [1:0]        cm;
    logic [1:0]        by;
    logic [1:0]        te;
    logic [1:0][7:0]   sk;

    always #5 clk = ~clk;

    frame_update_scheduler #(.FRAME_DIV(FD0), .TIMEOUT(TO)) u0 (
        .clk(clk), .rst(rst), .hsyncReg(h), .vsyncReg(v),
        .pause(pause), .compute_done(done),
        .ballIn(bin), .leftPaddleIn(lin), .rightPaddleIn(rin),
        .ballOut(bo[0]), .leftPaddleOut(lo[0]), .rightPaddleOut(ro[0]),
        .compute_start(cs[0]), .commit(cm[0]), .busy(by[0]),
        .skip_cnt(sk[0]), .timeout_err(te[0])
    );

    frame_update_scheduler #(.FRAME_DIV(FD1), .TIMEOUT(TO)) u1 (
        .clk(clk), .rst(rst), .hsyncReg(h), .vsyncReg(v),
        .pause(pause), .compute_done(done),
        .ballIn(bin), .leftPaddleIn(lin), .rightPaddleIn(rin),
        .ballOut(bo[1]), .leftPaddleOut(lo[1]), .rightPaddleOut(ro[1]),
        .compute_start(cs[1]), .commit(cm[1]), .busy(by[1]),
        .skip_cnt(sk[1]), .timeout_err(te[1])
    );

    typedef struct {
        bit          is_commit;
        int          cyc;
        logic [31:0] b;
        logic [31:0] l;
        logic [31:0] r;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  n_st[2];
    int  n_cm[2];

    bit          m_prev;
    int          m_phase[2];
    int          m_frames[2];
    int          m_skip[2];
    bit          m_err[2];
    int          m_start[2];
    logic [31:0] m_b[2];
    logic [31:0] m_l[2];
    logic [31:0] m_r[2];

    bit          fix;
    logic [31:0] fixv;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int fdiv(input int i);
        return (i == 0) ? FD0 : FD1;
    endfunction

    task automatic push(input int i, input ev_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic popq(input int i, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{0, 0, 0, 0, 0};
        if (i == 0 && q0.size() > 0) begin
            e  = q0.pop_front();
            ok = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
            e  = q1.pop_front();
            ok = 1'b1;
        end
    endtask

    // Reference: advances one clock with the inputs now applied. Updates
    // are tracked as "started at cycle S"; the engine is given TO cycles
    // after S to answer.
    task automatic model(input bit r);
        bit at;
        bit fe;
        int nxt;
        ev_t e;
        at = (h == 10'd639) && (v == 10'd479);
        fe = at && !m_prev;
        m_prev = r ? 1'b0 : at;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_phase[i]  = PI;
                m_frames[i] = 0;
                m_skip[i]   = 0;
                m_err[i]    = 1'b0;
                m_b[i]      = 0;
                m_l[i]      = 0;
                m_r[i]      = 0;
            end else begin
                nxt = m_phase[i];
                if (fe) begin
                    if (m_phase[i] == PI) begin
                        m_frames[i] = (m_frames[i] + 1) % fdiv(i);
                        if (m_frames[i] == 0 && !pause) begin
                            nxt        = PS;
                            m_start[i] = cyc + 1;
                            e = '{0, cyc + 1, 0, 0, 0};
                            push(i, e);
                        end
                    end else if (m_skip[i] < 255) begin
                        m_skip[i]++;
                    end
                end
                if (m_phase[i] == PS) begin
                    nxt = PW;
                end else if (m_phase[i] == PW) begin
                    if (done) begin
                        nxt    = PC;
                        m_b[i] = bin;
                        m_l[i] = lin;
                        m_r[i] = rin;
                        e = '{1, cyc + 1, bin, lin, rin};
                        push(i, e);
                    end else if (cyc - m_start[i] >= TO) begin
                        m_err[i] = 1'b1;
                        nxt      = PI;
                    end
                end else if (m_phase[i] == PC) begin
                    nxt = PI;
                end
                m_phase[i] = nxt;
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        for (int i = 0; i < 2; i++) begin
            if (cs[i] === 1'b1) begin
                n_st[i]++;
                popq(i, e, ok);
                chk($sformatf("start%0d_expected", i), 32'(ok), 1);
                if (ok) begin
                    chk($sformatf("start%0d_kind", i), 32'(e.is_commit), 0);
                    chk($sformatf("start%0d_cycle", i), cyc, e.cyc);
                end
            end
            if (cm[i] === 1'b1) begin
                n_cm[i]++;
                popq(i, e, ok);
                chk($sformatf("commit%0d_expected", i), 32'(ok), 1);
                if (ok) begin
                    chk($sformatf("commit%0d_kind", i), 32'(e.is_commit), 1);
                    chk($sformatf("commit%0d_cycle", i), cyc, e.cyc);
                    chk($sformatf("commit%0d_ball", i), bo[i], e.b);
                    chk($sformatf("commit%0d_left", i), lo[i], e.l);
                    chk($sformatf("commit%0d_right", i), ro[i], e.r);
                end
            end
        end
    end

    task automatic step(input bit r, input logic [9:0] hh,
                        input logic [9:0] vv, input bit p, input bit d);
        rst   = r;
        h     = hh;
        v     = vv;
        pause = p;
        done  = d;
        bin   = fix ? fixv : $urandom();
        lin   = $urandom();
        rin   = $urandom();
        model(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit p);
        for (int k = 0; k < n; k++) step(0, 10'd0, 10'd0, p, 0);
    endtask

    task automatic frame(input bit p);
        step(0, 10'd639, 10'd479, p, 0);
        step(0, 10'd0, 10'd0, p, 0);
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) step(1, 10'd0, 10'd0, 0, 0);
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s%0d_skip", tag, i), 32'(sk[i]), m_skip[i]);
            chk($sformatf("%s%0d_err", tag, i), 32'(te[i]), 32'(m_err[i]));
            chk($sformatf("%s%0d_busy", tag, i), 32'(by[i]),
                32'(m_phase[i] != PI));
            chk($sformatf("%s%0d_ball", tag, i), bo[i], m_b[i]);
            chk($sformatf("%s%0d_left", tag, i), lo[i], m_l[i]);
            chk($sformatf("%s%0d_right", tag, i), ro[i], m_r[i]);
        end
    endtask

    initial begin
        int b0;
        int c0;
        int b1;
        int c1;
        bit rr;
        bit at;
        fix    = 1'b0;
        fixv   = 0;
        m_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_st[i]    = 0;
            n_cm[i]    = 0;
            m_phase[i] = PI;
            m_start[i] = 0;
        end

        step(1, 10'd639, 10'd479, 0, 0);
        step(1, 10'd0, 10'd0, 0, 0);
        step(1, 10'd0, 10'd0, 0, 0);
        chk("rst_ball0", bo[0], 0);
        chk("rst_busy1", 32'(by[1]), 0);
        chk("rst_skip0", 32'(sk[0]), 0);
        check_state("rst");

        // Divide-by-1 update with a fixed ball position.
        b0 = n_st[0];
        c0 = n_cm[0];
        frame(0);
        idle(4, 0);
        fix  = 1'b1;
        fixv = 32'h0064_0032;
        step(0, 10'd0, 10'd0, 0, 1);
        fix  = 1'b0;
        idle(3, 0);
        chk("basic_ball", bo[0], 32'h0064_0032);
        chk("basic_starts", n_st[0] - b0, 1);
        chk("basic_commits", n_cm[0] - c0, 1);
        check_state("basic");

        // Divide-by-3 and timeout without an engine answer.
        do_reset();
        b1 = n_st[1];
        c1 = n_cm[1];
        frame(0);
        idle(3, 0);
        frame(0);
        idle(3, 0);
        chk("div3_early", n_st[1] - b1, 0);
        frame(0);
        idle(20, 0);
        chk("div3_starts", n_st[1] - b1, 1);
        chk("to_err1", 32'(te[1]), 1);
        chk("to_commits1", n_cm[1] - c1, 0);
        chk("to_ball1", bo[1], 0);
        chk("skip_wait0", 32'(sk[0]), 2);
        check_state("div3");

        // Skips while busy, then saturation.
        do_reset();
        b0 = n_st[0];
        frame(0);
        idle(2, 0);
        frame(0);
        chk("skip_one", 32'(sk[0]), 1);
        chk("skip_nostart", n_st[0] - b0, 1);
        for (int k = 0; k < 400; k++) frame(0);
        chk("skip_sat0", 32'(sk[0]), 255);
        check_state("sat");

        // Pause blocks starts but not an update in flight.
        do_reset();
        b0 = n_st[0];
        c0 = n_cm[0];
        frame(1);
        idle(2, 1);
        chk("pause_nostart", n_st[0] - b0, 0);
        frame(0);
        idle(2, 0);
        idle(3, 1);
        step(0, 10'd0, 10'd0, 1, 1);
        idle(2, 1);
        chk("pause_starts", n_st[0] - b0, 1);
        chk("pause_commit", n_cm[0] - c0, 1);
        check_state("pause");

        // Reset mid-wait drops the late done pulse.
        do_reset();
        c0 = n_cm[0];
        frame(0);
        idle(2, 0);
        chk("rw_busy_pre", 32'(by[0]), 1);
        step(1, 10'd0, 10'd0, 0, 0);
        step(0, 10'd0, 10'd0, 0, 1);
        idle(2, 0);
        chk("rw_commits", n_cm[0] - c0, 0);
        chk("rw_ball", bo[0], 0);
        chk("rw_busy", 32'(by[0]), 0);
        check_state("rw");

        // Random traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rr = ($urandom_range(499) == 0);
            at = ($urandom_range(3) == 0);
            step(rr,
                 at ? 10'd639 : 10'(($urandom_range(1023))),
                 at ? 10'd479 : 10'(($urandom_range(1023))),
                 ($urandom_range(7) == 0),
                 ($urandom_range(4) == 0));
            if (k % 100 == 99) check_state("rnd");
        end
        idle(20, 0);
        check_state("end");
        chk("left_q0", q0.size(), 0);
        chk("left_q1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 Parameter HSYNC_ACTIVE, default 639: last active horizontal pixel index.
REQ-002 Parameter VSYNC_ACTIVE, default 479: last active vertical line index.
REQ-003 Parameter FRAME_DIV, default 1, range 1..255: one game update per FRAME_DIV frames.
REQ-004 Parameter TIMEOUT, default 1024, at least 2: maximum cycles to wait for compute_done.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 hsyncReg  input  10  current horizontal pixel counter from the VGA driver.
REQ-008 vsyncReg  input  10  current vertical line counter from the VGA driver.
REQ-009 pause  input  1  level; while high, no new updates are started.
REQ-010 compute_done  input  1  one-cycle pulse from the ping-pong compute engine; update finished.
REQ-011 ballIn, leftPaddleIn, rightPaddleIn  input  32 each  positions produced by the compute engine.
REQ-012 ballOut, leftPaddleOut, rightPaddleOut  output  32 each  committed positions to the pixel generator.
REQ-013 compute_start  output  1  one-cycle pulse requesting one engine update.
REQ-014 commit  output  1  one-cycle pulse; the position outputs changed this cycle.
REQ-015 busy  output  1  high in START, WAIT_DONE and COMMIT.
REQ-016 skip_cnt  output  8  saturating count of frame ends that occurred while busy.
REQ-017 timeout_err  output  1  sticky; set when the engine fails to respond within TIMEOUT.

Function
REQ-018 frame_end SHALL be a one-cycle internal event, asserted on the first cycle in which (hsyncReg==HSYNC_ACTIVE && vsyncReg==VSYNC_ACTIVE) is true after a cycle in which it was false (rising-edge detect on a registered copy).
REQ-019 The FSM SHALL have exactly four states: IDLE, START, WAIT_DONE, COMMIT.
REQ-020 IDLE: on frame_end, the 8-bit frame divider SHALL increment; if the divider value before the increment equals FRAME_DIV-1, the divider SHALL clear, and the FSM SHALL go to START if pause=0 or stay in IDLE if pause=1 (the divider still clears).
REQ-021 START: compute_start=1 for exactly this cycle; the timeout counter SHALL clear; next state is WAIT_DONE unconditionally.
REQ-022 WAIT_DONE: if compute_done=1, next state is COMMIT; otherwise, when the timeout counter reaches TIMEOUT-1, set timeout_err and go to IDLE with no commit; otherwise increment the counter.
REQ-023 compute_done is ignored in every state except WAIT_DONE.
REQ-024 COMMIT: all three position outputs SHALL load their inputs in the same cycle (atomic), commit=1 for this cycle only; next state is IDLE.
REQ-025 Position outputs SHALL change only on a COMMIT cycle or on reset; they are never torn mid-frame.
REQ-026 A frame_end seen in START, WAIT_DONE or COMMIT SHALL increment skip_cnt, saturating at 255; it SHALL NOT advance the divider and SHALL NOT queue an update.
REQ-027 Update latency: compute_start is asserted 1 cycle after frame_end; commit is asserted 1 cycle after compute_done is sampled.
REQ-028 pause SHALL NOT abort an update already in progress.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE; divider, timeout counter, skip_cnt=0; all position outputs=0; compute_start, commit, busy, timeout_err=0; frame_end edge register=0.
REQ-030 Reset asserted in any state, including mid-WAIT_DONE, SHALL take effect on that edge; a compute_done arriving afterwards SHALL be ignored.

Verification
REQ-031 FRAME_DIV=1: drive counters to (639,479); compute_start pulses 1 cycle later; compute_done 5 cycles later with ball=0x00640032 -> commit pulse 1 cycle after done, ballOut=0x00640032.
REQ-032 FRAME_DIV=3: three frame ends -> exactly one compute_start, after the third.
REQ-033 TIMEOUT=16, no compute_done -> back to IDLE after 16 WAIT_DONE cycles, timeout_err=1, outputs unchanged, commit never pulses.
REQ-034 A frame end while in WAIT_DONE -> skip_cnt=1 and no second compute_start; 300 forced skips -> skip_cnt=255.
REQ-035 pause=1 across a frame end -> no compute_start; pause raised during WAIT_DONE -> the update still commits.
REQ-036 rst during WAIT_DONE, then compute_done -> no commit, all outputs 0, state IDLE.
